scan_addr_gen: RTL and testbench
================================

SCAN_ADDR_GEN -- requirements
Module: scan_addr_gen

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input and internal dwell counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort the scan in progress.
REQ-006 mode  input  1  0 = single sweep, 1 = continuous (wrap) sweep; captured at start.
REQ-007 mask  input  8  channel enable, bit i enables channel i; captured at start.
REQ-008 dwell  input  DWELL_W  extra hold cycles per channel; captured at start.
REQ-009 sel  output  3  registered channel index; drives the 3-to-8 decoder input.
REQ-010 sel_valid  output  1  registered; high while sel addresses an active channel.
REQ-011 busy  output  1  registered; high in state SCAN.
REQ-012 done  output  1  registered; one-cycle pulse at scan completion.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-014 In IDLE with start=1, stop=0 and mask!=0, the block SHALL do all of the following at the next edge:
- capture mask, mode and dwell;
- load sel with the lowest set bit index of mask;
- load the dwell counter with dwell;
- set sel_valid=1 and busy=1;
- enter SCAN.
REQ-015 In IDLE with start=1, stop=0 and mask==0, the block SHALL pulse done for one cycle and remain in IDLE with sel_valid=0.
REQ-016 In IDLE with start=1 and stop=1 in the same cycle, stop SHALL win: no capture, no done, state unchanged.
REQ-017 In SCAN with the dwell counter nonzero, the block SHALL decrement the counter by 1 each cycle and hold sel.
REQ-018 In SCAN with the dwell counter zero, the block SHALL advance sel to the next higher set bit of the captured mask and reload the counter with the captured dwell.
REQ-019 Each active channel SHALL therefore be presented for exactly dwell+1 cycles; dwell=0 gives one cycle per channel.
REQ-020 When no higher set bit exists and mode=1, sel SHALL wrap to the lowest set bit of the captured mask with no gap cycle.
REQ-021 When no higher set bit exists and mode=0, at the next edge the block SHALL:
- enter IDLE;
- clear sel_valid and busy;
- pulse done for exactly one cycle;
- hold sel at its last value.
REQ-022 stop=1 in SCAN SHALL, at the next edge, enter IDLE, clear sel_valid and busy, keep done=0, and hold sel; stop takes priority over advance and completion in the same cycle.
REQ-023 start asserted in SCAN SHALL be ignored.
REQ-024 Changes to mask, mode or dwell during SCAN SHALL have no effect until the next accepted start.
REQ-025 A single-bit captured mask SHALL hold sel constant:
- mode=1: sel_valid stays high until stop;
- mode=0: completion occurs after dwell+1 cycles.
REQ-026 sel SHALL never present an index whose captured mask bit is 0 while sel_valid=1.
REQ-027 The dwell counter SHALL be an unsigned DWELL_W-bit counter; the all-ones dwell value SHALL be legal and SHALL NOT overflow.

Reset
REQ-028 Asserting rst SHALL immediately force the following, regardless of clock, including mid-scan:
- state=IDLE;
- sel=3'b000, sel_valid=0, busy=0, done=0;
- dwell counter=0, captured mask=0, captured mode=0, captured dwell=0.
REQ-029 After rst deasserts, the block SHALL accept a start no earlier than the first rising edge with rst low.

Verification
REQ-030 Single sweep: mask=8'b1010_0101, dwell=1, mode=0, start for one cycle -> sel=0,0,2,2,5,5,7,7 with sel_valid=1 and busy=1; next cycle sel_valid=0, busy=0, done=1 for one cycle, sel=7.
REQ-031 Continuous: mask=8'b1000_0001, dwell=0, mode=1 -> sel=0,7,0,7,... with no gap; stop mid-scan -> sel_valid=0 and busy=0 next cycle, done stays 0.
REQ-032 Empty mask: mask=8'h00, start -> done=1 for one cycle, sel_valid and busy stay 0.
REQ-033 Priority: start=1 with stop=1 in IDLE -> nothing happens; stop on the final dwell cycle of a single sweep -> IDLE with done=0.
REQ-034 Reset mid-scan: assert rst between clock edges while sel=5 -> sel=0, sel_valid=0, busy=0 immediately; a fresh start after release restarts from the lowest set bit.
REQ-035 Full range: mask=8'hFF, dwell=all-ones (255), mode=0 -> each sel from 0 to 7 held 256 cycles, then done; the bench SHALL also check that a mask change during SCAN is ignored.

Source files
------------

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: steps a 3-bit channel select through the enabled channels of a mask,
// holding each for dwell+1 cycles, in single-sweep or continuous mode.
module scan_addr_gen #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t             state_q;
  logic [2:0]         sel_q;
  logic               sel_valid_q, busy_q, done_q, mode_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic [2:0]         nxt_sel;
  logic               nxt_ok;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  // Descending walk so the last hit is the nearest enabled channel above sel.
  always_comb begin
    nxt_ok  = 1'b0;
    nxt_sel = sel_q;
    for (int i = 7; i >= 0; i--)
      if (mask_q[i] && 3'(i) > sel_q) begin
        nxt_ok  = 1'b1;
        nxt_sel = 3'(i);
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      mask_q      <= 8'd0;
      mode_q      <= 1'b0;
      dwell_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start && !stop) begin
          if (mask != 8'd0) begin
            mask_q      <= mask;
            mode_q      <= mode;
            dwell_q     <= dwell;
            cnt_q       <= dwell;
            sel_q       <= lowest(mask);
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end else begin
            done_q <= 1'b1;
          end
        end
      end else if (stop) begin
        state_q     <= IDLE;
        sel_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (nxt_ok || mode_q) begin
        sel_q <= nxt_ok ? nxt_sel : lowest(mask_q);
        cnt_q <= dwell_q;
      end else begin
        state_q     <= IDLE;
        sel_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
      end
    end
  end
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_scan_addr_gen.sv
// tb_scan_addr_gen: directed checks of scan_addr_gen against hand-computed sequences.
module tb_scan_addr_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0] mask = 8'd0, dwell = 8'd0;
  logic [2:0] sel;
  logic       sel_valid, busy, done;
  int         checks = 0, errors = 0;
  scan_addr_gen #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [2:0] s, input logic v, input logic b, input logic d);
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".valid"}, 32'(sel_valid), 32'(v));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask
  initial begin
    logic [2:0] seq_a [8] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
    tick();
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    // single sweep
    mask = 8'hA5; dwell = 8'd1; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_out($sformatf("sweep%0d", k), seq_a[k], 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk_out("sweep_end", 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk("sweep_done_pulse", 32'(done), 32'd0);
    // continuous wrap with mid-scan mask change, then stop
    mask = 8'h81; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mask = 8'h02;
    for (int k = 0; k < 6; k++) begin
      chk_out($sformatf("cont%0d", k), (k % 2 == 0) ? 3'd0 : 3'd7, 1'b1, 1'b1, 1'b0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("cont_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("cont_stop_done", 32'(done), 32'd0);
    // empty mask
    mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("empty", 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("empty_after", 3'd0, 1'b0, 1'b0, 1'b0);
    // start and stop together in IDLE
    mask = 8'h08; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_out("startstop", 3'd0, 1'b0, 1'b0, 1'b0);
    // stop on final dwell cycle; start during SCAN ignored
    mask = 8'h06; dwell = 8'd1; mode = 1'b0; start = 1'b1;
    tick();
    chk_out("pri0", 3'd1, 1'b1, 1'b1, 1'b0);
    mask = 8'h80;
    tick();
    chk_out("pri1", 3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("pri2", 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    chk_out("pri3", 3'd2, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("pri_stop", 3'd2, 1'b0, 1'b0, 1'b0);
    // async reset mid-scan at sel=5
    mask = 8'hA5; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk_out("pre_rst", 3'd5, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    mask = 8'h24; dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("restart0", 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("restart1", 3'd5, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("restart_end", 3'd5, 1'b0, 1'b0, 1'b1);
    // full range, max dwell, inputs changed during SCAN
    mask = 8'hFF; dwell = 8'hFF; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; mask = 8'h01; dwell = 8'd0; mode = 1'b1;
    for (int c = 0; c < 8; c++)
      for (int j = 0; j < 256; j++) begin
        if (j == 0 || j == 255)
          chk_out($sformatf("full%0d_%0d", c, j), 3'(c), 1'b1, 1'b1, 1'b0);
        tick();
      end
    chk_out("full_end", 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk("full_done_pulse", 32'(done), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
